// File: rtl/mux_2x1_if.sv
// mux_2x1_if: operand/select/result bundle for the mux_2x1 steering element.
// With MUX_2X1_SEL_CNT_EN defined the bundle also carries the select-toggle count.
interface mux_2x1_if #(
   parameter int unsigned WIDTH = 1
`ifdef MUX_2X1_SEL_CNT_EN
   ,
   parameter int unsigned CNT_W = 8
`endif
);
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sel;
   logic             in_valid;
   logic [WIDTH-1:0] y;
   logic [WIDTH-1:0] y_q;
   logic             out_valid;
   logic             sel_q;
`ifdef MUX_2X1_SEL_CNT_EN
   logic [CNT_W-1:0] sel_toggles;
`endif

   // Producer side: drives operands, observes results.
   modport master (
      output a, b, sel, in_valid,
      input  y, y_q, out_valid, sel_q
`ifdef MUX_2X1_SEL_CNT_EN
      , input sel_toggles
`endif
   );

   // Selector side: consumes operands, produces results.
   modport slave (
      input  a, b, sel, in_valid,
      output y, y_q, out_valid, sel_q
`ifdef MUX_2X1_SEL_CNT_EN
      , output sel_toggles
`endif
   );
endinterface

// File: rtl/mux_2x1.sv
// mux_2x1: two-input selector with a zero-latency result and a registered,
// valid-qualified copy. Optional saturating select-toggle counter is compiled in
// when MUX_2X1_SEL_CNT_EN is defined.
module mux_2x1 #(
   parameter int unsigned WIDTH = 1
`ifdef MUX_2X1_SEL_CNT_EN
   ,
   parameter int unsigned CNT_W = 8
`endif
) (
   input  logic      clk,
   input  logic      rst,
   mux_2x1_if.slave  bus
);

   logic [WIDTH-1:0] y_q;
   logic             sel_q;
   logic             out_valid;

   // Zero-latency select; an unknown sel merges a and b bitwise.
   assign bus.y = bus.sel ? bus.b : bus.a;

   // Capture result and select on accepted cycles; valid follows in_valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y_q       <= '0;
         sel_q     <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= bus.in_valid;
         if (bus.in_valid) begin
            y_q   <= bus.sel ? bus.b : bus.a;
            sel_q <= bus.sel;
         end
      end
   end

   assign bus.y_q       = y_q;
   assign bus.sel_q     = sel_q;
   assign bus.out_valid = out_valid;

`ifdef MUX_2X1_SEL_CNT_EN
   logic [CNT_W-1:0] sel_toggles;
   logic             cnt_sat_c;

   assign cnt_sat_c = &sel_toggles;

   // Count accepted select changes against the last captured select; hold at max.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_toggles <= '0;
      end else if (bus.in_valid && (bus.sel != sel_q) && !cnt_sat_c) begin
         sel_toggles <= sel_toggles + CNT_W'(1);
      end
   end

   assign bus.sel_toggles = sel_toggles;
`endif

endmodule

// File: tb/tb_mux_2x1.sv
// tb_mux_2x1: table-driven combinational check on a 1-bit instance plus a
// scoreboarded registered-path, reset and counter check on an 8-bit instance.
module tb_mux_2x1;

   logic clk;
   logic rst;

   mux_2x1_if #(.WIDTH(1)) bus1 ();
`ifdef MUX_2X1_SEL_CNT_EN
   mux_2x1_if #(.WIDTH(8), .CNT_W(2)) bus8 ();
`else
   mux_2x1_if #(.WIDTH(8)) bus8 ();
`endif

   mux_2x1 #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
`ifdef MUX_2X1_SEL_CNT_EN
   mux_2x1 #(.WIDTH(8), .CNT_W(2)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
`else
   mux_2x1 #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic sel;
      logic a;
      logic b;
      logic y;
   } vec_t;

   typedef struct packed {
      logic [7:0] yq;
      logic       selq;
   } exp_t;

   vec_t vecs [8];
   exp_t sb_q [$];

   int n_chk  = 0;
   int n_fail = 0;

   logic [7:0] m_yq;
   logic       m_selq;
   int         m_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_yq   = 8'h00;
      m_selq = 1'b0;
      m_cnt  = 0;
      sb_q.delete();
   endtask

   // One clock of stimulus on the 8-bit instance, checked after the edge.
   task automatic drive_cycle(input logic [7:0] a, input logic [7:0] b,
                              input logic sel, input logic v);
      exp_t e;
      @(negedge clk);
      bus8.a        = a;
      bus8.b        = b;
      bus8.sel      = sel;
      bus8.in_valid = v;
      #1;
      chk("y_comb", 32'(bus8.y), 32'(sel ? b : a));
      if (v) begin
         if ((sel != m_selq) && (m_cnt < 3)) m_cnt++;
         m_yq   = sel ? b : a;
         m_selq = sel;
         e.yq   = m_yq;
         e.selq = m_selq;
         sb_q.push_back(e);
      end
      @(posedge clk);
      #1;
      chk("out_valid", 32'(bus8.out_valid), 32'(v));
      if (v) begin
         if (sb_q.size() == 0) begin
            chk("sb_empty", 32'(1), 32'(0));
         end else begin
            e = sb_q.pop_front();
            chk("y_q", 32'(bus8.y_q), 32'(e.yq));
            chk("sel_q", 32'(bus8.sel_q), 32'(e.selq));
         end
      end else begin
         chk("y_q_hold", 32'(bus8.y_q), 32'(m_yq));
         chk("sel_q_hold", 32'(bus8.sel_q), 32'(m_selq));
      end
`ifdef MUX_2X1_SEL_CNT_EN
      chk("sel_toggles", 32'(bus8.sel_toggles), 32'(m_cnt));
`endif
   endtask

   initial begin
      vecs[0] = '{sel: 1'b0, a: 1'b0, b: 1'b0, y: 1'b0};
      vecs[1] = '{sel: 1'b0, a: 1'b0, b: 1'b1, y: 1'b0};
      vecs[2] = '{sel: 1'b0, a: 1'b1, b: 1'b0, y: 1'b1};
      vecs[3] = '{sel: 1'b0, a: 1'b1, b: 1'b1, y: 1'b1};
      vecs[4] = '{sel: 1'b1, a: 1'b0, b: 1'b0, y: 1'b0};
      vecs[5] = '{sel: 1'b1, a: 1'b0, b: 1'b1, y: 1'b1};
      vecs[6] = '{sel: 1'b1, a: 1'b1, b: 1'b0, y: 1'b0};
      vecs[7] = '{sel: 1'b1, a: 1'b1, b: 1'b1, y: 1'b1};

      rst           = 1'b0;
      bus1.a        = 1'b0;
      bus1.b        = 1'b0;
      bus1.sel      = 1'b0;
      bus1.in_valid = 1'b0;
      bus8.a        = 8'h00;
      bus8.b        = 8'h00;
      bus8.sel      = 1'b0;
      bus8.in_valid = 1'b0;
      model_reset();
      #1 rst = 1'b1;
      #2;

      // Reset values.
      chk("rst_y_q", 32'(bus8.y_q), 32'(0));
      chk("rst_sel_q", 32'(bus8.sel_q), 32'(0));
      chk("rst_out_valid", 32'(bus8.out_valid), 32'(0));
`ifdef MUX_2X1_SEL_CNT_EN
      chk("rst_sel_toggles", 32'(bus8.sel_toggles), 32'(0));
      chk("rst_sel_toggles_w1", 32'(bus1.sel_toggles), 32'(0));
`endif

      // Exhaustive combinational table on the 1-bit instance.
      for (int i = 0; i < 8; i++) begin
         bus1.sel = vecs[i].sel;
         bus1.a   = vecs[i].a;
         bus1.b   = vecs[i].b;
         #10;
         chk($sformatf("tbl_y[%0d]", i), 32'(bus1.y), 32'(vecs[i].y));
         chk($sformatf("tbl_regs[%0d]", i),
             32'({bus1.y_q, bus1.sel_q, bus1.out_valid}), 32'(0));
      end

      @(negedge clk);
      rst = 1'b0;

      // Registered path: capture, then idle hold.
      drive_cycle(8'h5A, 8'hC3, 1'b1, 1'b1);
      chk("cap_C3", 32'(bus8.y_q), 32'h0000_00C3);
      drive_cycle(8'h11, 8'h22, 1'b0, 1'b0);
      chk("hold_C3", 32'(bus8.y_q), 32'h0000_00C3);

      // Back-to-back and random mixes.
      drive_cycle(8'hA5, 8'h3C, 1'b0, 1'b1);
      drive_cycle(8'hFF, 8'h00, 1'b1, 1'b1);
      for (int i = 0; i < 12; i++) begin
         drive_cycle(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      end

      // Asynchronous reset between edges while out_valid is high.
      drive_cycle(8'h77, 8'h99, 1'b1, 1'b1);
      chk("pre_rst_valid", 32'(bus8.out_valid), 32'(1));
      #2 rst = 1'b1;
      #1;
      chk("arst_y_q", 32'(bus8.y_q), 32'(0));
      chk("arst_sel_q", 32'(bus8.sel_q), 32'(0));
      chk("arst_out_valid", 32'(bus8.out_valid), 32'(0));
      chk("arst_y", 32'(bus8.y), 32'h0000_0099);
`ifdef MUX_2X1_SEL_CNT_EN
      chk("arst_sel_toggles", 32'(bus8.sel_toggles), 32'(0));
`endif
      model_reset();
      @(negedge clk);
      rst = 1'b0;

      // Alternating select: count saturates at 3.
      for (int i = 0; i < 6; i++) begin
         drive_cycle(8'(i), 8'(8'hF0 + i), 1'(i % 2), 1'b1);
      end
`ifdef MUX_2X1_SEL_CNT_EN
      chk("cnt_sat", 32'(bus8.sel_toggles), 32'(3));
`endif
      drive_cycle(8'h01, 8'h02, 1'b0, 1'b1);

      // Idle cycles with select toggling leave state alone.
      for (int i = 0; i < 4; i++) begin
         drive_cycle(8'h33, 8'h44, 1'(i % 2 == 0), 1'b0);
      end
`ifdef MUX_2X1_SEL_CNT_EN
      chk("cnt_idle", 32'(bus8.sel_toggles), 32'(3));
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mux_2x1.md
# mux_2x1

Two-input selector with a combinational result and a registered copy. It picks operand `a` when `sel`=0 and operand `b` when `sel`=1. It serves as the basic steering element in datapaths that need both a zero-latency select and a clean, registered, valid-qualified version of the same result. An optional select-activity counter supports debug and coverage.

## Interface
- `WIDTH`, default 1: operand and result width in bits (≥1).
- `CNT_W`, default 8: width of the select-toggle counter (≥2); used only when the counter is compiled in.

- `clk`  in  1  rising-edge clock for all registers.
- `rst`  in  1  reset; asynchronous, active-high; clears all registers.
- `a`  in  WIDTH  operand selected when `sel`=0.
- `b`  in  WIDTH  operand selected when `sel`=1.
- `sel`  in  1  select.
- `in_valid`  in  1  qualifies `a`/`b`/`sel` for the registered path.
- `y`  out  WIDTH  combinational result: `sel` ? `b` : `a`.
- `y_q`  out  WIDTH  registered result.
- `out_valid`  out  1  `y_q` holds a result captured under `in_valid`.
- `sel_q`  out  1  select value that produced `y_q`.
- `sel_toggles`  out  CNT_W  saturating count of accepted select changes; present only with the counter macro.

## Operation
- `y` is purely combinational and independent of `clk` and `rst`:
  - `sel`=0 → `y`=`a`.
  - `sel`=1 → `y`=`b`.
  - `sel`=X/Z → each bit of `y` equals the common value of `a` and `b` where they agree, X otherwise (standard `?:` semantics).
- Registered path, on a rising `clk` with `in_valid`=1:
  - `y_q` ← `sel` ? `b` : `a`; `sel_q` ← `sel`; `out_valid` ← 1.
- With `in_valid`=0: `y_q` and `sel_q` hold; `out_valid` ← 0.
- No backpressure: every `in_valid` cycle is accepted.
- Counter, when compiled in:
  - On an accepted cycle whose `sel` differs from `sel_q`, `sel_toggles` increments by 1.
  - It saturates at 2^CNT_W−1 and never wraps.
  - The first accepted cycle after reset compares against the reset value `sel_q`=0.
- No state machine: the block holds only pipeline registers and the optional counter.

## Timing
- `y`: zero-cycle latency, changes in the same delta as its inputs.
- `y_q`, `sel_q`, `out_valid`: 1-cycle latency from the accepting edge.
- Reset values: `y_q`=0, `sel_q`=0, `out_valid`=0, `sel_toggles`=0.
- `rst` asserted mid-operation:
  - Clears the registered outputs immediately, without waiting for `clk`.
  - `y` continues to follow its inputs.
- The first capture happens on the first rising `clk` after `rst` deasserts with `in_valid`=1.
- `in_valid` high on consecutive cycles gives back-to-back results, one per cycle.

## Configuration
- `MUX_2X1_SEL_CNT_EN` defined:
  - The `sel_toggles` port and the saturating counter are present.
- Not defined:
  - The port and the counter logic are omitted entirely.
  - All other behaviour is identical.

## Test plan
- Exhaustive, `WIDTH`=1, no clock required:
  - Apply the 8 combinations of (`sel`,`a`,`b`), 10 time units each.
  - Required: `y`=0,0,1,1 for `sel`=0 with (a,b)=00,01,10,11.
  - Required: `y`=0,1,0,1 for `sel`=1 with the same (a,b) order.
- Registered path, `WIDTH`=8:
  - Drive `a`=8'h5A, `b`=8'hC3, `sel`=1, `in_valid`=1 for one cycle.
  - Next cycle: `y_q`=8'hC3, `sel_q`=1, `out_valid`=1.
  - The following cycle with `in_valid`=0: `out_valid`=0 and `y_q` still 8'hC3.
- Reset:
  - Assert `rst` asynchronously between edges while `out_valid`=1.
  - Required immediately: `y_q`=0, `sel_q`=0, `out_valid`=0, and `y` still equal to the selected input.
- Counter (macro defined, `CNT_W`=2):
  - Alternate `sel` 0,1,0,1,0,1 with `in_valid`=1.
  - Required: `sel_toggles` reaches 3 and stays 3.
  - Idle cycles with `sel` toggling and `in_valid`=0 leave the count unchanged.
- Build without the macro:
  - Compiles, and `sel_toggles` is absent.
  - The registered-path scenario passes identically.
